fifo_fwft: RTL and testbench

FIFO_FWFT -- requirements
Module: fifo_fwft

---
 rtl/fifo_fwft.sv | 142 ++++++++++++++
 tb/tb_fifo_fwft.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft.sv
// ---------------------------------------------------------------------------
// fifo_fwft
// Converts the 1-cycle-latency rd_en/valid read port of an upstream fifo into
// a first-word-fall-through valid/ready stream. A two-entry holding buffer
// (head, tail) absorbs the read latency. Up to two words are in flight or
// buffered at any time. That is enough for one word per cycle with no loss,
// duplication or reordering.
//
// Parameters
//   dta_width   width of fifo words and of the output stream
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active low
//   fifo_dout   upstream read data, valid the cycle after an accepted read
//   fifo_empty  upstream empty flag
//   fifo_valid  upstream read acknowledge, qualifies fifo_dout
//   fifo_rd_en  read enable to the upstream fifo
//   dout        head word of the output stream (registered)
//   dout_valid  dout holds a valid word
//   dout_ready  consumer accepts dout this cycle
//   stall_cnt   saturating count of cycles with dout_valid & ~dout_ready
//               (present only when FIFO_FWFT_STATS_EN is defined)
//
// Build options
//   FIFO_FWFT_STATS_EN  adds the stall_cnt port and its counter
// ---------------------------------------------------------------------------
module fifo_fwft #(
   parameter int dta_width = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [dta_width-1:0] fifo_dout,
   input  logic                 fifo_empty,
   input  logic                 fifo_valid,
   output logic                 fifo_rd_en,
   output logic [dta_width-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready
`ifdef FIFO_FWFT_STATS_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);

   logic [1:0]           occ_q, occ_d;
   logic                 inflight_q;
   logic [dta_width-1:0] head_q, head_d;
   logic [dta_width-1:0] tail_q, tail_d;

   logic                 pop;
   logic                 capture;
   logic [2:0]           committed;

   // NOTE: combinational blocks use blocking '=' and assign every output a
   // default first, so no path can leave a signal unassigned and infer a latch.
   always_comb begin
      pop        = (occ_q != 2'd0) & dout_ready;
      // A stray fifo_valid with no read outstanding is not ours to take.
      capture    = fifo_valid & inflight_q;
      // Slots already spoken for once this cycle's pop has left.
      committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_rd_en = rst & ~fifo_empty & (committed < 3'd2);

      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         2'd0: begin
            if (capture) begin
               head_d = fifo_dout;
               occ_d  = 2'd1;
            end
         end
         2'd1: begin
            if (capture && pop) begin
               head_d = fifo_dout;
            end else if (capture) begin
               tail_d = fifo_dout;
               occ_d  = 2'd2;
            end else if (pop) begin
               occ_d  = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d = tail_q;
               if (capture) begin
                  tail_d = fifo_dout;
               end else begin
                  occ_d  = 2'd1;
               end
            end
         end
         default: occ_d = occ_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples
   // the values from before the edge. The holding buffer is only two words
   // and dout must read 0 in reset, so head and tail are reset as well.
   always_ff @(posedge clk) begin
      if (!rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   assign dout       = head_q;
   assign dout_valid = (occ_q != 2'd0);

   // A capture into a full buffer without a pop means a word is lost.
   // The rd_en throttle is meant to make that impossible.
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(capture && (occ_q == 2'd2) && !pop))
            else $error("fifo_fwft: capture into full holding buffer");
      end
   end

`ifdef FIFO_FWFT_STATS_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= 16'h0000;
      end else if (dout_valid && !dout_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_fifo_fwft
// Drives fifo_fwft from a behavioural upstream fifo (a queue with a 1-cycle
// read latency). The upstream can optionally drop acknowledges or raise stray
// valids. Every word written upstream is recorded in an expected-order ring.
// A negedge monitor pops that ring on every dout_valid & dout_ready. It also
// tracks how many words the block holds from the observed read handshakes,
// and uses that count to check dout_valid, the rd_en throttle and hold stability.
// Build option mirrored from the design: FIFO_FWFT_STATS_EN.
// ---------------------------------------------------------------------------
module tb_fifo_fwft;

   localparam int W    = 8;
   localparam int RING = 1024;

   logic         clk        = 1'b0;
   logic         rst        = 1'b0;
   logic [W-1:0] fifo_dout  = '0;
   logic         fifo_empty = 1'b1;
   logic         fifo_valid = 1'b0;
   logic         fifo_rd_en;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready = 1'b0;
`ifdef FIFO_FWFT_STATS_EN
   logic [15:0]  stall_cnt;
`endif

   // stimulus controls for the upstream model
   logic         wr_en     = 1'b0;
   logic [W-1:0] wr_data   = '0;
   logic         flush_req = 1'b0;
   logic         glitch_en = 1'b0;

   // upstream contents and expected output order
   logic [W-1:0] up_q[$];
   logic [W-1:0] exp_mem [0:RING-1];
   int           wr_idx = 0;
   int           rd_idx = 0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fifo_fwft #(.dta_width(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_valid (fifo_valid),
      .fifo_rd_en (fifo_rd_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
`ifdef FIFO_FWFT_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- upstream fifo model (1-cycle read latency) ------------
   always @(posedge clk) begin
      if (!rst) begin
         fifo_valid <= 1'b0;
         if (flush_req) up_q.delete();
      end else if (fifo_rd_en && up_q.size() != 0) begin
         if (glitch_en && $urandom_range(0, 3) == 0) begin
            fifo_valid <= 1'b0;               // underflow: acknowledge lost
         end else begin
            fifo_dout  <= up_q.pop_front();
            fifo_valid <= 1'b1;
         end
      end else begin
         // stray acknowledge with no read outstanding
         fifo_valid <= glitch_en && ($urandom_range(0, 3) == 0);
         fifo_dout  <= 8'hEE;
      end
      if (wr_en) begin
         up_q.push_back(wr_data);
         exp_mem[wr_idx % RING] = wr_data;
         wr_idx++;
      end
      fifo_empty <= (up_q.size() == 0);
   end

   // ---------------- monitor / scoreboard ----------------------------------
   int           held       = 0;
   int           inflight_m = 0;
   bit           rst_prev   = 1'b1;
   bit           stall_prev = 1'b0;
   logic [W-1:0] prev_dout  = '0;

   always @(negedge clk) begin
      bit pop, cap;
      if (!rst) begin
         check("rst_rd_en", fifo_rd_en, 0);
         if (!rst_prev) begin
            check("rst_dout_valid", dout_valid, 0);
            check("rst_dout", dout, 0);
         end
         if (flush_req) rd_idx = wr_idx;
         held       = 0;
         inflight_m = 0;
         stall_prev = 1'b0;
      end else begin
         pop = dout_valid && dout_ready;
         cap = fifo_valid && (inflight_m != 0);
         check("dout_valid_vs_held", dout_valid, held != 0);
         check("rd_en_throttle", fifo_rd_en,
               !fifo_empty && (held + inflight_m - int'(pop) < 2));
         check("occ_bound", (held + int'(cap) - int'(pop)) <= 2, 1);
         if (stall_prev) begin
            check("hold_valid", dout_valid, 1);
            check("hold_dout", dout, prev_dout);
         end
         if (pop) begin
            check("sb_pending", wr_idx != rd_idx, 1);
            check("dout_order", dout, exp_mem[rd_idx % RING]);
            rd_idx++;
         end
         held       = held + int'(cap) - int'(pop);
         inflight_m = int'(fifo_rd_en);
         stall_prev = dout_valid && !dout_ready;
         prev_dout  = dout;
      end
      rst_prev = rst;
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      tick();
      dout_ready = 1'b1;
      for (int i = 0; i < budget && !(wr_idx == rd_idx && !dout_valid); i++) tick();
      check("drain_pending", wr_idx - rd_idx, 0);
   endtask

   task automatic flush_reset();
      flush_req = 1'b1;
      rst       = 1'b0;
      tick();
      tick();
      rst       = 1'b1;
      flush_req = 1'b0;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int run;

      // reset held for 3 cycles while the upstream fifo fills
      rst = 1'b0;
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      rst = 1'b1;
      wait_drain(50);

      // single word latency, then held under backpressure
      dout_ready = 1'b0;
      write_word(8'hA5);
      @(negedge clk); check("lat_cycle0_valid", dout_valid, 0);
      @(negedge clk); check("lat_cycle1_valid", dout_valid, 0);
      @(negedge clk); check("lat_cycle2_valid", dout_valid, 1);
      check("lat_cycle2_dout", dout, 8'hA5);
      repeat (8) @(negedge clk);
      check("hold_a5_valid", dout_valid, 1);
      check("hold_a5_dout", dout, 8'hA5);
      wait_drain(20);

      // streaming: 16 words preloaded, then one word per cycle
      dout_ready = 1'b0;
      for (int i = 0; i < 16; i++) write_word(W'(i));
      tick();
      dout_ready = 1'b1;
      run = 0;
      repeat (16) begin
         @(negedge clk);
         if (dout_valid && dout_ready) run++;
      end
      check("stream_run", run, 16);
      @(negedge clk); check("drain_valid_low", dout_valid, 0);
      repeat (3) begin
         @(negedge clk); check("drain_rd_en_low", fifo_rd_en, 0);
      end
      wait_drain(20);

      // backpressure pattern 1,0,0 over 0x00..0x0F
      for (int c = 0; c < 16; c++) begin
         dout_ready = (c % 3 == 0);
         wr_en      = 1'b1;
         wr_data    = W'(c);
         tick();
      end
      wr_en = 1'b0;
      for (int c = 16; c < 80; c++) begin
         dout_ready = (c % 3 == 0);
         tick();
      end
      wait_drain(50);

      // randomized traffic with upstream underflow and stray acknowledges
      glitch_en = 1'b1;
      for (int c = 0; c < 600; c++) begin
         wr_en   = ($urandom_range(0, 2) != 0);
         wr_data = W'($urandom);
         if (c < 200)      dout_ready = ($urandom_range(0, 1) != 0);
         else if (c < 400) dout_ready = 1'b1;
         else              dout_ready = ($urandom_range(0, 4) == 0);
         tick();
      end
      wr_en = 1'b0;
      wait_drain(2000);
      glitch_en = 1'b0;

      // reset mid-operation discards buffered and in-flight words
      dout_ready = 1'b0;
      for (int i = 0; i < 6; i++) write_word(W'(8'h80 + i));
      tick();
      flush_reset();
      @(negedge clk); check("post_flush_valid", dout_valid, 0);
      tick();
      write_word(8'h5A);
      write_word(8'hC3);
      wait_drain(30);

`ifdef FIFO_FWFT_STATS_EN
      flush_reset();
      @(negedge clk); check("stall_reset", stall_cnt, 0);
      tick();
      dout_ready = 1'b0;
      write_word(8'h77);
      for (int i = 0; i < 20 && !dout_valid; i++) @(negedge clk);
      check("stall_valid_seen", dout_valid, 1);
      check("stall_start", stall_cnt, 0);
      repeat (10) @(negedge clk);
      check("stall_10", stall_cnt, 10);
      repeat (70000) @(negedge clk);
      check("stall_saturate", stall_cnt, 16'hFFFF);
      wait_drain(20);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
